// File: rtl/noc_pkg.sv
// noc_pkg: packet field positions and hop helper shared by the ring router blocks.
package noc_pkg;
  localparam int PAC_WIDTH   = 64;
  localparam int VC_BIT      = 63;
  localparam int DIR_BIT     = 62;
  localparam int HOP_MSB     = 55;
  localparam int HOP_LSB     = 48;
  localparam int PAYLOAD_MSB = 47;
  // A packet that has already run out of hops stays at zero instead of wrapping.
  function automatic logic [7:0] hop_dec(input logic [7:0] hop);
    return (hop == 8'd0) ? 8'd0 : hop - 8'd1;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin with one pointer per virtual channel.
// Ports: clk, reset (sync, active-high); req_i[0]=ring, req_i[1]=PE;
// vc_i selects which pointer arbitrates; gnt_o is one-hot or zero.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       vc_i,
  output logic [1:0] gnt_o
);
  logic [1:0] ptr_q, ptr_d;
  // Pointer names the favoured requester and flips to the loser only on contention.
  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_q[vc_i]);
    gnt_o[1] = req_i[1] & (~req_i[0] | ptr_q[vc_i]);
    ptr_d = ptr_q;
    ptr_d[vc_i] = (&req_i) ? ~ptr_q[vc_i] : ptr_q[vc_i];
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 2'b00;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/ring_output_arbiter.sv
// ring_output_arbiter: shares one ring output link between ring forwarding and PE injection.
// Ports: clk, reset (sync, active-high); polarity (0 = even cycle);
// ring_si/ring_di/ring_ri and pe_si/pe_di/pe_ri are the two requesters (ri = pop);
// out_so/out_ro/out_do is the output link; hop_err is sticky on a hop==0 ring packet.
module ring_output_arbiter #(
  parameter int PAC_WIDTH = noc_pkg::PAC_WIDTH,
  parameter int HOP_MSB   = noc_pkg::HOP_MSB,
  parameter int HOP_LSB   = noc_pkg::HOP_LSB
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 polarity,
  input  logic                 ring_si,
  input  logic [PAC_WIDTH-1:0] ring_di,
  output logic                 ring_ri,
  input  logic                 pe_si,
  input  logic [PAC_WIDTH-1:0] pe_di,
  output logic                 pe_ri,
  output logic                 out_so,
  input  logic                 out_ro,
  output logic [PAC_WIDTH-1:0] out_do,
  output logic                 hop_err
);
  localparam int VC_BIT = PAC_WIDTH - 1;
  logic                 polarity_q, polarity_d;
  logic [1:0]           valid_q, valid_d;
  logic [PAC_WIDTH-1:0] obuf_q [2];
  logic [PAC_WIDTH-1:0] obuf_d [2];
  logic                 hop_err_q, hop_err_d;
  logic [1:0]           req, gnt;
  logic [PAC_WIDTH-1:0] ring_pkt, wr_pkt;
  logic                 p;
  assign p = polarity_q;
  // Only the entry matching this cycle's polarity can be filled; the other one drains.
  assign req[0] = ~reset & ring_si & (ring_di[VC_BIT] == p) & ~valid_q[p];
  assign req[1] = ~reset & pe_si & (pe_di[VC_BIT] == p) & ~valid_q[p];
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (req),
    .vc_i  (p),
    .gnt_o (gnt)
  );
  assign ring_ri  = gnt[0];
  assign pe_ri    = gnt[1];
  assign polarity = polarity_q;
  assign out_so   = valid_q[~p];
  assign out_do   = obuf_q[~p];
  assign hop_err  = hop_err_q;
  always_comb begin
    ring_pkt = ring_di;
    ring_pkt[HOP_MSB:HOP_LSB] = noc_pkg::hop_dec(ring_di[HOP_MSB:HOP_LSB]);
    wr_pkt = gnt[1] ? pe_di : ring_pkt;
    polarity_d = ~polarity_q;
    valid_d = valid_q;
    obuf_d = obuf_q;
    if (out_so && out_ro) valid_d[~p] = 1'b0;
    if (|gnt) begin
      valid_d[p] = 1'b1;
      obuf_d[p] = wr_pkt;
    end
    hop_err_d = hop_err_q | (gnt[0] && ring_di[HOP_MSB:HOP_LSB] == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_q <= 1'b0;
      valid_q    <= 2'b00;
      obuf_q     <= '{default: '0};
      hop_err_q  <= 1'b0;
    end else begin
      polarity_q <= polarity_d;
      valid_q    <= valid_d;
      obuf_q     <= obuf_d;
      hop_err_q  <= hop_err_d;
    end
  end
endmodule

// File: tb/tb_ring_output_arbiter.sv
// tb_ring_output_arbiter: directed self-checking bench for ring_output_arbiter.
module tb_ring_output_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        polarity;
  logic        ring_si = 1'b0;
  logic [63:0] ring_di = '0;
  logic        ring_ri;
  logic        pe_si = 1'b0;
  logic [63:0] pe_di = '0;
  logic        pe_ri;
  logic        out_so;
  logic        out_ro = 1'b1;
  logic [63:0] out_do;
  logic        hop_err;
  int          errors = 0;
  int          checks = 0;
  logic        ep = 1'b0;

  ring_output_arbiter dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .ring_si(ring_si), .ring_di(ring_di), .ring_ri(ring_ri),
    .pe_si(pe_si), .pe_di(pe_di), .pe_ri(pe_ri),
    .out_so(out_so), .out_ro(out_ro), .out_do(out_do), .hop_err(hop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ep <= reset ? 1'b0 : ~ep;

  function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [7:0] hop, input logic [47:0] pl);
    return {vc, dir, 6'b0, hop, pl};
  endfunction

  task automatic test_reset();
    reset = 1'b1; out_ro = 1'b1;
    ring_si = 1'b1; ring_di = mk(1'b0, 1'b0, 8'd1, 48'h11);
    pe_si = 1'b1; pe_di = mk(1'b0, 1'b0, 8'd1, 48'h22);
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (polarity !== 1'b0) begin errors++; $display("FAIL reset_polarity got=%b want=0", polarity); end
      checks++; if (out_so !== 1'b0 || out_do !== 64'd0) begin errors++; $display("FAIL reset_out got so=%b do=%h want so=0 do=0", out_so, out_do); end
      checks++; if (ring_ri !== 1'b0 || pe_ri !== 1'b0) begin errors++; $display("FAIL reset_grants got ring=%b pe=%b want 0 0", ring_ri, pe_ri); end
      checks++; if (hop_err !== 1'b0) begin errors++; $display("FAIL reset_hop_err got=%b want=0", hop_err); end
    end
    @(negedge clk);
    reset = 1'b0; ring_si = 1'b0; pe_si = 1'b0;
    #1;
    checks++; if (polarity !== 1'b0) begin errors++; $display("FAIL release_polarity got=%b want=0", polarity); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (polarity !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL idle_polarity[%0d] got=%b want=%b", i, polarity, (i % 2 == 0)); end
      checks++; if (out_so !== 1'b0 || ring_ri !== 1'b0 || pe_ri !== 1'b0 || hop_err !== 1'b0) begin errors++; $display("FAIL idle_outputs[%0d] got so=%b rr=%b pr=%b he=%b want 0000", i, out_so, ring_ri, pe_ri, hop_err); end
    end
  endtask

  task automatic test_ring_only();
    logic [63:0] q[$];
    logic [63:0] exp;
    out_ro = 1'b1; pe_si = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      ring_si = (k < 10);
      ring_di = mk(ep, 1'b0, 8'd1, 48'hA000 + 48'(k));
      #1;
      checks++; if (ring_ri !== (k < 10) || pe_ri !== 1'b0) begin errors++; $display("FAIL ring_grant[%0d] got ring=%b pe=%b want ring=%b pe=0", k, ring_ri, pe_ri, (k < 10)); end
      if (k > 0) begin
        exp = q.pop_front();
        checks++; if (out_so !== 1'b1 || out_do !== exp) begin errors++; $display("FAIL ring_out[%0d] got so=%b do=%h want so=1 do=%h", k, out_so, out_do, exp); end
      end
      if (k < 10) q.push_back(mk(ep, 1'b0, 8'd0, 48'hA000 + 48'(k)));
    end
    ring_si = 1'b0;
  endtask

  task automatic test_pe_only();
    logic [63:0] q[$];
    logic [63:0] exp;
    out_ro = 1'b1; ring_si = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      pe_si = (k < 10);
      pe_di = mk(ep, k[0], 8'd1, 48'hB000 + 48'(k));
      #1;
      checks++; if (pe_ri !== (k < 10) || ring_ri !== 1'b0) begin errors++; $display("FAIL pe_grant[%0d] got pe=%b ring=%b want pe=%b ring=0", k, pe_ri, ring_ri, (k < 10)); end
      if (k > 0) begin
        exp = q.pop_front();
        checks++; if (out_so !== 1'b1 || out_do !== exp) begin errors++; $display("FAIL pe_out[%0d] got so=%b do=%h want so=1 do=%h", k, out_so, out_do, exp); end
      end
      if (k < 10) q.push_back(pe_di);
    end
    pe_si = 1'b0;
  endtask

  task automatic test_contention();
    logic        turn = 1'b0;
    logic        pend = 1'b0;
    logic [63:0] last = '0;
    out_ro = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ring_si = 1'b1; pe_si = 1'b1;
      ring_di = mk(1'b0, 1'b0, 8'd3, 48'hC00 + 48'(k));
      pe_di   = mk(1'b0, 1'b1, 8'd3, 48'hD00 + 48'(k));
      #1;
      if (ep == 1'b0) begin
        checks++; if (ring_ri !== ~turn || pe_ri !== turn) begin errors++; $display("FAIL contend_even[%0d] got ring=%b pe=%b want ring=%b pe=%b", k, ring_ri, pe_ri, ~turn, turn); end
        last = turn ? pe_di : mk(1'b0, 1'b0, 8'd2, 48'hC00 + 48'(k));
        pend = 1'b1;
        turn = ~turn;
      end else begin
        checks++; if (ring_ri !== 1'b0 || pe_ri !== 1'b0) begin errors++; $display("FAIL contend_odd[%0d] got ring=%b pe=%b want 0 0", k, ring_ri, pe_ri); end
        if (pend) begin
          checks++; if (out_so !== 1'b1 || out_do !== last) begin errors++; $display("FAIL contend_out[%0d] got so=%b do=%h want so=1 do=%h", k, out_so, out_do, last); end
          pend = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (ep == 1'b0) begin
      ring_si = 1'b0; pe_si = 1'b0;
      @(negedge clk);
    end
    ring_si = 1'b1; pe_si = 1'b1;
    ring_di = mk(1'b1, 1'b0, 8'd9, 48'hE01);
    pe_di   = mk(1'b1, 1'b1, 8'd9, 48'hE02);
    #1;
    checks++; if (ring_ri !== 1'b1 || pe_ri !== 1'b0) begin errors++; $display("FAIL vc1_ptr_untouched got ring=%b pe=%b want ring=1 pe=0", ring_ri, pe_ri); end
    if (pend) begin
      checks++; if (out_so !== 1'b1 || out_do !== last) begin errors++; $display("FAIL contend_out_tail got so=%b do=%h want so=1 do=%h", out_so, out_do, last); end
    end
    @(negedge clk);
    ring_si = 1'b0; pe_si = 1'b0;
    #1;
    checks++; if (out_so !== 1'b1 || out_do !== mk(1'b1, 1'b0, 8'd8, 48'hE01)) begin errors++; $display("FAIL vc1_out got so=%b do=%h want so=1 do=%h", out_so, out_do, mk(1'b1, 1'b0, 8'd8, 48'hE01)); end
  endtask

  task automatic test_backpressure();
    logic [63:0] p_exp, q_exp;
    ring_si = 1'b0; pe_si = 1'b0; out_ro = 1'b1;
    do @(negedge clk); while (ep !== 1'b0);
    ring_si = 1'b1; ring_di = mk(1'b0, 1'b0, 8'd5, 48'hF0); out_ro = 1'b0;
    p_exp = mk(1'b0, 1'b0, 8'd4, 48'hF0);
    q_exp = mk(1'b0, 1'b0, 8'd6, 48'hF1);
    #1;
    checks++; if (ring_ri !== 1'b1) begin errors++; $display("FAIL bp_first_grant got=%b want=1", ring_ri); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      ring_di = mk(1'b0, 1'b0, 8'd7, 48'hF1);
      #1;
      checks++; if (ring_ri !== 1'b0) begin errors++; $display("FAIL bp_blocked[%0d] got=%b want=0", i, ring_ri); end
      checks++; if (out_so !== 1'(i % 2)) begin errors++; $display("FAIL bp_so[%0d] got=%b want=%0d", i, out_so, i % 2); end
      if (i % 2 == 1) begin
        checks++; if (out_do !== p_exp) begin errors++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, out_do, p_exp); end
      end
    end
    @(negedge clk);
    out_ro = 1'b1;
    #1;
    checks++; if (out_so !== 1'b1 || out_do !== p_exp || ring_ri !== 1'b0) begin errors++; $display("FAIL bp_release got so=%b do=%h rr=%b want so=1 do=%h rr=0", out_so, out_do, ring_ri, p_exp); end
    @(negedge clk); #1;
    checks++; if (ring_ri !== 1'b1 || out_so !== 1'b0) begin errors++; $display("FAIL bp_resume got rr=%b so=%b want rr=1 so=0", ring_ri, out_so); end
    @(negedge clk);
    ring_si = 1'b0;
    #1;
    checks++; if (out_so !== 1'b1 || out_do !== q_exp) begin errors++; $display("FAIL bp_next_out got so=%b do=%h want so=1 do=%h", out_so, out_do, q_exp); end
    @(negedge clk); #1;
    checks++; if (out_so !== 1'b0) begin errors++; $display("FAIL bp_no_dup got so=%b want=0", out_so); end
  endtask

  task automatic test_hop_zero_and_reset();
    logic [63:0] exp;
    out_ro = 1'b1; pe_si = 1'b0;
    @(negedge clk);
    ring_si = 1'b1; ring_di = mk(ep, 1'b0, 8'd0, 48'hDEAD);
    exp = ring_di;
    #1;
    checks++; if (ring_ri !== 1'b1 || hop_err !== 1'b0) begin errors++; $display("FAIL hop0_grant got rr=%b he=%b want rr=1 he=0", ring_ri, hop_err); end
    @(negedge clk);
    ring_si = 1'b0;
    #1;
    checks++; if (out_so !== 1'b1 || out_do !== exp) begin errors++; $display("FAIL hop0_out got so=%b do=%h want so=1 do=%h", out_so, out_do, exp); end
    checks++; if (hop_err !== 1'b1) begin errors++; $display("FAIL hop0_err_rise got=%b want=1", hop_err); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (hop_err !== 1'b1) begin errors++; $display("FAIL hop0_err_sticky[%0d] got=%b want=1", i, hop_err); end
    end
    out_ro = 1'b0;
    @(negedge clk);
    ring_si = 1'b1; ring_di = mk(ep, 1'b0, 8'd4, 48'h1);
    #1;
    checks++; if (ring_ri !== 1'b1) begin errors++; $display("FAIL fill_a got=%b want=1", ring_ri); end
    @(negedge clk);
    ring_si = 1'b0; pe_si = 1'b1; pe_di = mk(ep, 1'b0, 8'd4, 48'h2);
    #1;
    checks++; if (pe_ri !== 1'b1 || out_so !== 1'b1) begin errors++; $display("FAIL fill_b got pr=%b so=%b want 1 1", pe_ri, out_so); end
    @(negedge clk);
    pe_si = 1'b0; reset = 1'b1;
    #1;
    checks++; if (out_so !== 1'b1 || out_do !== mk(1'b1 ^ ep, 1'b0, 8'd4, 48'h2)) begin errors++; $display("FAIL full_before_reset got so=%b do=%h", out_so, out_do); end
    @(negedge clk); #1;
    checks++; if (out_so !== 1'b0 || out_do !== 64'd0) begin errors++; $display("FAIL midreset_out got so=%b do=%h want so=0 do=0", out_so, out_do); end
    checks++; if (hop_err !== 1'b0 || polarity !== 1'b0) begin errors++; $display("FAIL midreset_state got he=%b pol=%b want 0 0", hop_err, polarity); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (polarity !== 1'b0 || out_so !== 1'b0) begin errors++; $display("FAIL post_reset got pol=%b so=%b want 0 0", polarity, out_so); end
    @(negedge clk); #1;
    checks++; if (polarity !== 1'b1 || out_so !== 1'b0) begin errors++; $display("FAIL post_reset_next got pol=%b so=%b want 1 0", polarity, out_so); end
  endtask

  initial begin
    test_reset();
    test_ring_only();
    test_pe_only();
    test_contention();
    test_backpressure();
    test_hop_zero_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ring_output_arbiter.md
Name: ring_output_arbiter

Overview:
Output-port controller for one ring direction (cw or ccw) of the gold router.
- Shares the output link between two requesters: the ring-forwarding buffer of the same direction and the PE injection buffer.
- Owns the router's even/odd polarity flip-flop and a two-entry output stage, one packet per virtual channel.
- Decrements the hop field on forwarded traffic.
- One instance sits behind each of cwdo/ccwdo. The PE-ejection path is outside this block.

Parameters:
PAC_WIDTH, 64, packet width; bit 63 = vc, bit 62 = dir, [55:48] = hop, [47:0] = payload
HOP_MSB, 55, hop field MSB
HOP_LSB, 48, hop field LSB

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
polarity  out  1  router polarity; 0 = even cycle
ring_si  in  1  ring-forwarding buffer has a packet
ring_di  in  PAC_WIDTH  ring-forwarding packet
ring_ri  out  1  grant/pop to ring buffer (combinational)
pe_si  in  1  PE injection buffer has a packet
pe_di  in  PAC_WIDTH  PE injection packet
pe_ri  out  1  grant/pop to PE buffer (combinational)
out_so  out  1  output link send
out_ro  in  1  downstream ready
out_do  out  PAC_WIDTH  output link data
hop_err  out  1  sticky: ring packet arrived with hop == 0

Behaviour:
Clocking and reset:
- One clock domain; reset is synchronous and active-high.
- On reset: polarity = 0, obuf_valid[1:0] = 0, obuf data = 0, rr_ptr[1:0] = 0 (ring favoured on both VCs), hop_err = 0.
- Consequently out_so = 0 and out_do = 0 after reset; ring_ri and pe_ri are 0 while reset is high.
- Reset mid-operation discards buffered packets with no drain.

Polarity:
- Toggles every cycle after reset: 0,1,0,1...

Eligibility and grant (cycle with polarity p):
- Requester X is eligible iff X_si = 1, X_di[63] == p, and obuf_valid[p] == 0.
- At most one grant per cycle; ring_ri and pe_ri are never both 1.
- Only ring eligible -> ring_ri = 1. Only PE eligible -> pe_ri = 1.
- Both eligible -> rr_ptr[p] picks the winner: 0 = ring, 1 = PE. rr_ptr[p] then flips to point at the loser.
- rr_ptr[p] changes only on a contested grant. rr_ptr[~p] is untouched.
- The requester treats X_ri as a pop, valid at the clock edge.

Write on grant (at the edge):
- obuf[p] <= packet, obuf_valid[p] <= 1.
- Ring-sourced packet: hop field <= hop - 1, all other bits unchanged.
- PE-sourced packet: written unchanged.
- Ring packet with hop == 0: still granted and consumed. Written with hop = 0 (no wrap to 0xFF). hop_err <= 1, sticky until reset.

Drain (cycle with polarity p):
- out_so = obuf_valid[~p], out_do = obuf[~p].
- Transfer occurs when out_so && out_ro; at the edge obuf_valid[~p] <= 0.
- When out_so = 0, out_do is unspecified for checking purposes; implementation drives obuf[~p].
- The buffer being filled (p) and the buffer being drained (~p) are always distinct, so there is no same-entry fill/drain conflict.

Latency and throughput:
- A packet granted in the polarity-p cycle appears on out_so in the next cycle.
- If out_ro = 0, the packet retries two cycles later, at the next polarity ~p cycle. Data is held stable; there is no loss or duplication.
- Peak throughput: one packet per VC every 2 cycles, aggregate 1 packet per cycle.

Decomposition:
- Shared package noc_pkg: PAC_WIDTH; field positions VC_BIT = 63, DIR_BIT = 62, HOP_MSB/HOP_LSB, PAYLOAD_MSB = 47; a hop_dec function that saturates at 0.
- One natural sub-module: rr_arb2. It is a 2-requester round-robin with per-VC pointer, taking req[1:0] and vc select and producing gnt[1:0] and the pointer update.
- The obuf/polarity logic stays in the top module.

Test Plan:
1. Reset 3 cycles, then release with no requests -> polarity alternates 0,1,0..., out_so = 0, ring_ri = pe_ri = 0, hop_err = 0.
2. Ring only, ring_si = 1, vc alternating to match polarity, hop = 1, out_ro = 1 -> ring_ri every cycle. Each packet appears on out_do one cycle later with hop = 0 and payload intact; 10 packets in, 10 out, in order.
3. PE only, pedi vc alternating, dir alternating, hop = 1 -> pe_ri every cycle; out_do equals pe_di unchanged (hop still 1), one cycle latency.
4. Contention, both si = 1, both vc = 0 -> on even cycles grants go ring, PE, ring, PE...; no grant on odd cycles; rr_ptr[1] unchanged.
5. Backpressure, out_ro = 0 for 6 cycles after a VC0 grant -> out_so high only on odd cycles; further VC0 grants blocked (ring_ri = 0). Raise out_ro -> packet delivered once, then VC0 grants resume.
6. Ring packet with hop = 0 -> granted, out_do hop = 0x00, hop_err rises and stays 1. Assert reset mid-stream with both obufs full -> out_so = 0, hop_err = 0, and polarity = 0 in the cycle after the reset edge.
